// File: rtl/layer_4_input_packer.sv
// Layer-4 input packer: gathers channel-serial words into one pixel vector and
// strobes it in raster order over a single IMG_SIZE x IMG_SIZE frame.
module layer_4_input_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int IMG_SIZE   = 104,
    parameter int CNT_W      = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
    output logic                           valid_out,
    output logic [CNT_W-1:0]               row,
    output logic [CNT_W-1:0]               col,
    output logic                           frame_done
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state, state_next;
    logic [CH_W-1:0]                ch;
    logic [CNT_W-1:0]               row_cnt, col_cnt;
    logic [DATA_WIDTH-1:0]          lanes [CHANNELS];
    logic [DATA_WIDTH*CHANNELS-1:0] pixel_vec;
    logic                           run, accept, pixel_last_word, col_wrap, frame_last;

    assign run             = (state == RUN);
    assign ready_out       = run;
    assign accept          = valid_in & run;
    assign pixel_last_word = accept && (ch == CH_W'(CHANNELS - 1));
    assign col_wrap        = (col_cnt == CNT_W'(IMG_SIZE - 1));
    assign frame_last      = col_wrap && (row_cnt == CNT_W'(IMG_SIZE - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (pixel_last_word && frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The lane being written this cycle is bypassed so the final word joins the vector directly.
    always_comb begin
        pixel_vec = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pixel_vec[k*DATA_WIDTH +: DATA_WIDTH] = (ch == CH_W'(k)) ? data_in : lanes[k];
        end
    end

    // Lane storage carries no reset: a restarted pixel overwrites every lane before it is emitted.
    always_ff @(posedge clk) begin
        if (accept) lanes[ch] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            state      <= state_next;
            valid_out  <= pixel_last_word;
            frame_done <= pixel_last_word && frame_last;
            if (accept) begin
                ch <= pixel_last_word ? '0 : ch + 1'b1;
            end
            if (pixel_last_word) begin
                data_out <= pixel_vec;
                row      <= row_cnt;
                col      <= col_cnt;
                if (col_wrap) begin
                    col_cnt <= '0;
                    row_cnt <= frame_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/layer_4_input_packer.md
# layer_4_input_packer

Producer side of the layer-4 feature-map input bus. Collects channel-serial 32-bit fp32 words, one channel per accepted beat. Packs each group of CHANNELS words into one wide pixel vector and drives it as a single-cycle `valid_out` strobe, in raster order over one IMG_SIZE x IMG_SIZE frame. Sits between the layer-3 output/memory reader and the `layer_4_featuremap_*` instances, whose `data_in`/`valid_in` it feeds directly.

## Interface
- DATA_WIDTH, 32, width of one channel word (fp32).
- CHANNELS, 32, words packed per pixel.
- IMG_SIZE, 104, frame width and height in pixels.
- CNT_W, 7, width of row/col outputs (>= clog2(IMG_SIZE)).

- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- data_in  in  DATA_WIDTH  channel word.
- valid_in  in  1  data_in valid.
- ready_out  out  1  packer accepts a word this cycle.
- data_out  out  DATA_WIDTH*CHANNELS  packed pixel; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  1  one-cycle strobe, data_out holds a new pixel.
- row  out  CNT_W  row of pixel on data_out.
- col  out  CNT_W  column of pixel on data_out.
- frame_done  out  1  one-cycle pulse with the last pixel of a frame.

## Operation
- States:
  - IDLE: ready_out=0.
  - RUN: ready_out=1.
- Transitions:
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on the cycle the last pixel's final word (channel CHANNELS-1 of pixel (IMG_SIZE-1, IMG_SIZE-1)) is accepted.
  - `start` in RUN is ignored.
- Accept: a word is taken when `valid_in & ready_out`. `valid_in` in IDLE is ignored and the data is dropped.
- Channel counter `ch`, 0..CHANNELS-1:
  - The accepted word is stored in lane `ch`; `ch` increments.
  - `ch` wraps to 0 after CHANNELS-1.
- Pixel emit: on acceptance with `ch == CHANNELS-1`:
  - The full vector (CHANNELS-1 held lanes plus the current word) is loaded into the `data_out` register.
  - `row`/`col` are loaded with the current pixel counters.
  - `valid_out` asserts.
- Pixel counters:
  - `col` increments per emitted pixel and wraps IMG_SIZE-1 -> 0.
  - `row` increments on each `col` wrap.
  - Both clear to 0 at frame end.
- `frame_done` asserts together with `valid_out` of pixel (IMG_SIZE-1, IMG_SIZE-1).
- No backpressure from downstream: `valid_out` is never held. `data_out`, `row` and `col` keep their last value between strobes.
- Gaps in `valid_in` mid-pixel are legal; partial lanes persist.
- Reset mid-frame: the partial pixel is discarded, counters clear, state returns to IDLE. The next frame requires a new `start`.

## Timing
- Reset values: ready_out=0, valid_out=0, frame_done=0, data_out=0, row=0, col=0, ch=0, state IDLE.
- `start` at cycle t -> ready_out=1 from cycle t+1.
- Latency: last channel word accepted at edge t -> valid_out=1 during cycle t+1, for exactly one cycle.
- Throughput: one pixel per CHANNELS accepted beats. Back-to-back pixels are strobed every CHANNELS cycles with `valid_in` held high.
- Frame end:
  - ready_out drops to 0 the cycle after the final word is accepted, coinciding with the final valid_out/frame_done.
  - Total accepted words per frame: IMG_SIZE*IMG_SIZE*CHANNELS.
- A `start` on the same cycle as frame_done is accepted (state already IDLE). RUN resumes the next cycle with counters at 0.

## Test plan
- Reset and idle:
  - Stimulus: assert Rst=0 mid-cycle; release; drive `valid_in`=1 without `start` for 50 cycles.
  - Required response: all outputs at reset values, no valid_out, ready_out=0.
- Single pixel (IMG_SIZE=2, CHANNELS=32):
  - Stimulus: `start`, then words 0x3F800000+k for k=0..31.
  - Required response: one valid_out one cycle after the 32nd acceptance; lane k = 0x3F800000+k; row=0, col=0.
- Full frame (IMG_SIZE=4):
  - Stimulus: continuous `valid_in` for 512 words.
  - Required response: 16 strobes spaced 32 cycles; row/col raster (0,0)..(3,3) with col wrap at 3; frame_done only on the 16th strobe; ready_out=0 afterwards.
- Bubbles:
  - Stimulus: randomly deassert `valid_in` (50%) during a pixel.
  - Required response: same packed vector as the gap-free run; strobe one cycle after the 32nd accepted word.
- Reset mid-pixel:
  - Stimulus: after 17 words, pulse Rst low; `start` a new frame.
  - Required response: the first strobe contains only post-reset words; row=0, col=0.
- Restart:
  - Stimulus: `start` coincident with frame_done; stray `start` pulses during RUN.
  - Required response: second frame begins next cycle at (0,0); stray pulses change nothing.
